// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types for the unified-memory port arbiter. It defines
//               the owner encoding of a read tag, the arbitration FSM states,
//               the {valid, owner} tag carried through the read-latency
//               pipeline, and a helper that clears a fetch-owned tag on flush.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  // Width of the per-cycle count of invalidated fetch tags (RD_LAT <= 4).
  localparam int DROP_W = 3;

  typedef enum logic [0:0] {
    ST_NORMAL      = 1'b0,
    ST_FORCE_FETCH = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic valid;
    logic owner;
  } arb_tag_t;

  // A tag survives a flush unless it belongs to fetch.
  function automatic arb_tag_t flush_tag(arb_tag_t t, logic kill);
    arb_tag_t r;
    r = t;
    if (kill && (t.owner == OWN_FETCH)) r.valid = 1'b0;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : arb_tag_pipe
// Description : RD_LAT-deep shift register of read tags. Stage 0 captures
//               the tag of the access granted this cycle; the last stage is
//               the tag of the read whose data is on mem_rdata now. A flush
//               invalidates every fetch-owned tag as it advances, so fetches
//               already in flight never return. The tag entering stage 0 in
//               the flush cycle is the redirect target and is kept.
// Ports       : clk, rst_n  - clock, async active-low reset
//               flush       - drop in-flight fetch tags
//               tag_in      - tag of this cycle's grant
//               tag_out     - tag aligned with mem_rdata
//               drop_cnt    - fetch tags invalidated this cycle
//                             (only with MEM_ARB_STATS_EN defined)
// Revision    : 1.0 - initial release
// ============================================================================
module arb_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  arb_tag_t tag_in,
  output arb_tag_t tag_out
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [DROP_W-1:0] drop_cnt
`endif
);

  arb_tag_t r_stage [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) r_stage[i] <= flush_tag(r_stage[i-1], flush);
    end
  end

  // The last stage is delivered this cycle, so only stages that still
  // advance can be invalidated.
  assign tag_out = r_stage[RD_LAT-1];

`ifdef MEM_ARB_STATS_EN
  always_comb begin
    drop_cnt = '0;
    for (int i = 0; i < RD_LAT - 1; i++) begin
      if (flush && r_stage[i].valid && (r_stage[i].owner == OWN_FETCH))
        drop_cnt = drop_cnt + DROP_W'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single-port 16-bit unified memory between
//               instruction fetch and the load/store port. One grant per
//               cycle; data wins conflicts until it has won STREAK_MAX times
//               in a row against a waiting fetch, after which fetch is forced
//               through once. Reads are tagged so the response returns to its
//               owner RD_LAT cycles later; flush discards in-flight fetches.
//               Optional build macro MEM_ARB_STATS_EN adds conflict_cnt and
//               flush_drop_cnt saturating counters.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               if_req/if_addr/if_gnt          - fetch request side
//               if_rvalid/if_rdata             - fetch response
//               d_req/d_we/d_addr/d_wdata/d_gnt- load/store request side
//               d_rvalid/d_rdata               - load response
//               flush                          - taken branch
//               mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory macro
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [15:0] d_rdata,
  input  logic        flush,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] conflict_cnt,
  output logic [15:0] flush_drop_cnt
`endif
);

  localparam logic [3:0] C_STREAK_MAX = 4'(STREAK_MAX);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic [3:0] r_streak;
  logic [3:0] w_streak_nxt;
  arb_tag_t   w_tag_in;
  arb_tag_t   w_tag_out;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_NORMAL;
      r_streak <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  // Next state. The streak only counts data wins that made fetch wait; the
  // switch to FORCE_FETCH happens on the edge where the count reaches
  // STREAK_MAX so fetch wins the very next conflict.
  always_comb begin
    w_streak_nxt = r_streak;
    if (if_gnt || !if_req)
      w_streak_nxt = 4'd0;
    else if (d_gnt)
      w_streak_nxt = r_streak + 4'd1;

    w_state_nxt = r_state;
    if (r_state == ST_NORMAL) begin
      if (w_streak_nxt >= C_STREAK_MAX) w_state_nxt = ST_FORCE_FETCH;
    end else begin
      if (if_gnt) w_state_nxt = ST_NORMAL;
    end
  end

  // Grants. Held low during reset so the memory sees no access.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (rst_n) begin
      if ((r_state == ST_FORCE_FETCH) && if_req)
        if_gnt = 1'b1;
      else if (d_req)
        d_gnt = 1'b1;
      else if (if_req)
        if_gnt = 1'b1;
    end
  end

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = if_gnt ? if_addr : (d_gnt ? d_addr : 16'h0000);
  assign mem_wdata = d_gnt ? d_wdata : 16'h0000;

  // Stores produce no response, so they enter the pipe as an invalid tag.
  assign w_tag_in.valid = if_gnt | (d_gnt & ~d_we);
  assign w_tag_in.owner = d_gnt ? OWN_DATA : OWN_FETCH;

`ifdef MEM_ARB_STATS_EN
  logic [DROP_W-1:0] w_drop_cnt;
`endif

  arb_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .tag_in  (w_tag_in),
    .tag_out (w_tag_out)
`ifdef MEM_ARB_STATS_EN
    ,
    .drop_cnt(w_drop_cnt)
`endif
  );

  assign if_rvalid = w_tag_out.valid & (w_tag_out.owner == OWN_FETCH);
  assign d_rvalid  = w_tag_out.valid & (w_tag_out.owner == OWN_DATA);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

`ifdef MEM_ARB_STATS_EN
  logic [15:0] r_conflict_cnt;
  logic [15:0] r_flush_drop_cnt;
  logic [16:0] w_drop_sum;

  assign w_drop_sum = {1'b0, r_flush_drop_cnt} + 17'(w_drop_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt   <= 16'h0000;
      r_flush_drop_cnt <= 16'h0000;
    end else begin
      if (if_req && d_req && (r_conflict_cnt != 16'hFFFF))
        r_conflict_cnt <= r_conflict_cnt + 16'h0001;
      r_flush_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign conflict_cnt   = r_conflict_cnt;
  assign flush_drop_cnt = r_flush_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with RD_LAT=3 and
//               STREAK_MAX=4. A behavioural memory answers reads; a
//               scoreboard queues the expected response of every read grant
//               and compares it when rvalid arrives.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int RD_LAT     = 3;
  localparam int STREAK_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = 16'h0;
  logic        if_gnt, if_rvalid;
  logic [15:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [15:0] d_addr = 16'h0, d_wdata = 16'h0;
  logic        d_gnt, d_rvalid;
  logic [15:0] d_rdata;
  logic        flush = 1'b0;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [15:0] conflict_cnt, flush_drop_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(
    .RD_LAT(RD_LAT),
    .STREAK_MAX(STREAK_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .flush(flush),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .conflict_cnt(conflict_cnt), .flush_drop_cnt(flush_drop_cnt)
`endif
  );

  // Behavioural memory: write-first, data RD_LAT cycles after a read.
  logic [15:0] mem     [256];
  logic [15:0] ref_mem [256];
  logic [15:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Scoreboard
  typedef struct {
    int          due;
    logic [15:0] data;
  } exp_t;
  exp_t if_q[$];
  exp_t d_q[$];
  exp_t e_if, e_d;

  always @(negedge clk) begin
    if (!rst_n) begin
      if_q.delete();
      d_q.delete();
    end else begin
      if (if_rvalid) begin
        checks++;
        if (if_q.size() == 0) begin
          errors++;
          $display("FAIL if_resp_unexpected: got if_rvalid=1 want 0 at cycle %0d", cyc);
        end else begin
          e_if = if_q.pop_front();
          if (e_if.due != cyc || if_rdata !== e_if.data) begin
            errors++;
            $display("FAIL if_resp: got cycle %0d data %h want cycle %0d data %h",
                     cyc, if_rdata, e_if.due, e_if.data);
          end
        end
      end else if (if_q.size() != 0 && if_q[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL if_resp_missing: got if_rvalid=0 want 1 at cycle %0d", cyc);
        void'(if_q.pop_front());
      end

      if (d_rvalid) begin
        checks++;
        if (d_q.size() == 0) begin
          errors++;
          $display("FAIL d_resp_unexpected: got d_rvalid=1 want 0 at cycle %0d", cyc);
        end else begin
          e_d = d_q.pop_front();
          if (e_d.due != cyc || d_rdata !== e_d.data) begin
            errors++;
            $display("FAIL d_resp: got cycle %0d data %h want cycle %0d data %h",
                     cyc, d_rdata, e_d.due, e_d.data);
          end
        end
      end else if (d_q.size() != 0 && d_q[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL d_resp_missing: got d_rvalid=0 want 1 at cycle %0d", cyc);
        void'(d_q.pop_front());
      end

      // Fetches already in flight are cancelled; this cycle's grant is kept.
      if (flush) if_q.delete();

      if (if_gnt) if_q.push_back('{cyc + RD_LAT, ref_mem[if_addr[7:0]]});
      if (d_gnt && d_we) ref_mem[d_addr[7:0]] = d_wdata;
      else if (d_gnt) d_q.push_back('{cyc + RD_LAT, ref_mem[d_addr[7:0]]});
    end
  end

  task automatic drive_idle();
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; flush = 1'b0;
  endtask

  task automatic drain_and_check(input string name);
    repeat (RD_LAT + 2) @(posedge clk);
    checks++;
    if (if_q.size() != 0 || d_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d/%0d pending responses want 0/0", name, if_q.size(), d_q.size());
    end
  endtask

  task automatic test_reset();
    if_req = 1'b1; d_req = 1'b1; if_addr = 16'h0001; d_addr = 16'h0002;
    repeat (2) @(negedge clk);
    checks++;
    if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_grants: got gnt/en/we=%b want 0000", {if_gnt, d_gnt, mem_en, mem_we});
    end
    checks++;
    if ({if_rvalid, d_rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_rvalid: got %b want 00", {if_rvalid, d_rvalid});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_idle();
  endtask

  task automatic test_fetch_only();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1 || d_gnt !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gnt: got if_gnt=%b d_gnt=%b want 1 0", if_gnt, d_gnt);
    end
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin
      errors++;
      $display("FAIL fetch_mem: got en=%b we=%b addr=%h want 1 0 0010", mem_en, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || mem_addr !== 16'h0000 || mem_wdata !== 16'h0000) begin
      errors++;
      $display("FAIL idle_mem: got en=%b addr=%h wdata=%h want 0 0000 0000", mem_en, mem_addr, mem_wdata);
    end
    drain_and_check("fetch_only");
  endtask

  task automatic test_store_load();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0040 || mem_wdata !== 16'h1234) begin
      errors++;
      $display("FAIL store_mem: got gnt=%b we=%b addr=%h wdata=%h want 1 1 0040 1234",
               d_gnt, mem_we, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    d_we = 1'b0;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_en !== 1'b1) begin
      errors++;
      $display("FAIL load_mem: got gnt=%b we=%b en=%b want 1 0 1", d_gnt, mem_we, mem_en);
    end
    checks++;
    if (ref_mem[8'h40] !== 16'h1234) begin
      errors++;
      $display("FAIL store_model: got %h want 1234", ref_mem[8'h40]);
    end
    @(posedge clk); #1;
    drive_idle();
    drain_and_check("store_load");
  endtask

  task automatic test_streak();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0080;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0090;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      checks++;
      if (if_gnt !== ((k % 5) == 4) || d_gnt !== ((k % 5) != 4)) begin
        errors++;
        $display("FAIL streak_gnt[%0d]: got if_gnt=%b d_gnt=%b want %b %b",
                 k, if_gnt, d_gnt, (k % 5) == 4, (k % 5) != 4);
      end
      @(posedge clk); #1;
    end
    drive_idle();
`ifdef MEM_ARB_STATS_EN
    checks++;
    if (conflict_cnt !== 16'd15) begin
      errors++;
      $display("FAIL conflict_cnt: got %0d want 15", conflict_cnt);
    end
`endif
    drain_and_check("streak");
  endtask

  task automatic test_flush_fetch();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0020;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_f0_gnt: got %b want 1", if_gnt); end
    @(posedge clk); #1;
    if_addr = 16'h0021;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_f1_gnt: got %b want 1", if_gnt); end
    @(posedge clk); #1;
    if_addr = 16'h0030; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (if_gnt !== 1'b1) begin errors++; $display("FAIL flush_f2_gnt: got %b want 1", if_gnt); end
    @(posedge clk); #1;
    drive_idle();
`ifdef MEM_ARB_STATS_EN
    @(negedge clk);
    checks++;
    if (flush_drop_cnt !== 16'd2) begin
      errors++;
      $display("FAIL flush_drop_cnt: got %0d want 2", flush_drop_cnt);
    end
`endif
    drain_and_check("flush_fetch");
  endtask

  task automatic test_flush_load();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
    @(negedge clk);
    checks++;
    if (d_gnt !== 1'b1) begin errors++; $display("FAIL flush_load_gnt: got %b want 1", d_gnt); end
    @(posedge clk); #1;
    d_req = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    drain_and_check("flush_load");
  endtask

  task automatic test_reset_inflight();
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0011;
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b1; d_addr = 16'h0012;
    @(posedge clk); #1;
    drive_idle();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, d_rvalid, mem_en} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_quiet: got rvalid/en=%b want 000", {if_rvalid, d_rvalid, mem_en});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drain_and_check("reset_inflight");
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0060;
    d_req = 1'b1; d_addr = 16'h0061;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (if_gnt !== (k == 4) || d_gnt !== (k != 4)) begin
        errors++;
        $display("FAIL post_reset_gnt[%0d]: got if_gnt=%b d_gnt=%b want %b %b",
                 k, if_gnt, d_gnt, k == 4, k != 4);
      end
      @(posedge clk); #1;
    end
    drive_idle();
    drain_and_check("post_reset");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'(i * 16'h0101) ^ 16'h5A00;
      ref_mem[i] = 16'(i * 16'h0101) ^ 16'h5A00;
    end
    test_reset();
    test_fetch_only();
    test_store_load();
    test_streak();
    test_flush_fetch();
    test_flush_load();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port 16-bit unified memory between instruction fetch and the execute stage's load/store port. It grants one requester per cycle, tags each read so the response returns to its owner after a fixed latency, and bounds fetch starvation. On a taken branch it discards in-flight fetch responses. It sits between the fetch/execute stages and the memory macro; its grant outputs drive the pipeline stall logic.

## Interface
- RD_LAT, 1: memory read latency in cycles, legal range 1..4
- STREAK_MAX, 4: maximum consecutive data grants while fetch is waiting, legal range 1..15
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch read request
- if_addr  in  16  fetch address
- if_gnt  out  1  fetch request accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  16  fetch read data
- d_req  in  1  data request (load or store)
- d_we  in  1  data request is a store
- d_addr  in  16  data address
- d_wdata  in  16  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  16  load data
- flush  in  1  taken branch/jump; cancels outstanding fetch reads
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  16  memory address
- mem_wdata  out  16  memory write data
- mem_rdata  in  16  memory read data, valid RD_LAT cycles after an mem_en read

## Operation
- Grants are combinational from the requests and the registered state. At most one of if_gnt/d_gnt is high; mem_en = if_gnt | d_gnt.
- Memory outputs come from the granted port. mem_we = d_gnt & d_we. A fetch never writes. With no grant, mem_addr/mem_wdata hold 0.
- FSM states:
  - NORMAL: data wins any conflict.
  - FORCE_FETCH: fetch wins any conflict.
- Streak counter (4 bits):
  - Increments on each d_gnt cycle in which if_req is also high.
  - Clears on any if_gnt, or on any cycle with if_req low.
  - NORMAL→FORCE_FETCH when the counter reaches STREAK_MAX.
  - FORCE_FETCH→NORMAL after one if_gnt, which also clears the counter.
  - In FORCE_FETCH with if_req low, data is granted normally and the state is held.
- Tag pipeline: RD_LAT stages of {valid, owner}.
  - A read grant enters {1, owner}. A store or no-grant cycle enters {0, x}.
  - Stage RD_LAT-1 drives if_rvalid or d_rvalid. mem_rdata is routed to both rdata outputs unconditionally.
- flush clears the valid bit of every fetch-owned tag already in the pipeline.
  - A fetch granted in the same cycle as flush is kept, because it is the redirect target.
  - Data tags are never flushed.
- Address arithmetic is plain 16-bit; no wrap or bounds checks.

## Timing
- Reset values: if_gnt=0, d_gnt=0, if_rvalid=0, d_rvalid=0, mem_en=0, mem_we=0. All tags invalid, streak=0, state NORMAL.
- Outputs stay quiet while rst_n is low. Reset mid-operation drops all in-flight reads with no rvalid.
- Read latency: grant at cycle N produces rvalid at cycle N+RD_LAT. Throughput is one access per cycle.
- Requesters hold req and its payload stable until they see gnt.
- Store at N followed by a load of the same address at N+1 returns the new data; the memory handles write-first ordering.

## Configuration
- MEM_ARB_STATS_EN defined: adds outputs conflict_cnt[15:0] and flush_drop_cnt[15:0]. Both are saturating at 16'hFFFF and reset to 0.
  - conflict_cnt increments on each cycle with if_req & d_req.
  - flush_drop_cnt increments by the number of fetch tags invalidated in that cycle.
- MEM_ARB_STATS_EN undefined: these ports and counters do not exist. Arbitration behaviour is identical either way.

## Structure
- Shared package holds:
  - the owner encoding: OWN_FETCH=1'b0, OWN_DATA=1'b1
  - the FSM state enum {ST_NORMAL, ST_FORCE_FETCH}
  - the tag struct {valid, owner}
- One sub-module, arb_tag_pipe: a RD_LAT-deep tag shift register with a per-owner flush clear.

## Test plan
- Fetch only, if_addr=0x0010, RD_LAT=2 -> if_gnt same cycle; if_rvalid 2 cycles later with mem contents of 0x0010; d_rvalid stays 0.
- Store 0x1234 to 0x0040 then load 0x0040, fetch idle -> mem_we=1 only in cycle 1; d_rvalid with d_rdata=0x1234; no rvalid for the store.
- if_req and d_req held high continuously, STREAK_MAX=4 -> grant sequence D,D,D,D,F repeating; the FSM passes through FORCE_FETCH once per period.
- Fetch reads granted at cycles 0 and 1 with RD_LAT=3, flush at cycle 2 with a new fetch granted at cycle 2 -> only the cycle-2 fetch produces if_rvalid (at cycle 5); with stats, flush_drop_cnt=2.
- Load granted at cycle 0, flush at cycle 1 -> d_rvalid still asserted at cycle RD_LAT.
- rst_n low while two reads are in flight -> no rvalid after release; the first post-reset request is granted normally in NORMAL with streak=0.
